// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// Handshake: a byte moves on a rising clk edge where rx_valid and rx_ready
// are both 1; the source holds rx_data stable while rx_valid is high and
// rx_ready is low. imem_we is a single-cycle strobe qualifying imem_waddr and
// imem_wdata, with no back-pressure from the memory side.
interface imem_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_waddr;
    logic [31:0] imem_wdata;

    // Loader side: consumes the byte stream, drives the memory write port.
    modport master (
        input  rx_valid,
        input  rx_data,
        output rx_ready,
        output imem_we,
        output imem_waddr,
        output imem_wdata
    );

    // Environment side: byte source and memory.
    modport slave (
        output rx_valid,
        output rx_data,
        input  rx_ready,
        input  imem_we,
        input  imem_waddr,
        input  imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time program loader. Stream: N, N payload words, XOR checksum, all
// little-endian 32-bit. Payload words go to consecutive imem addresses from
// BASE_ADDR; loader_done releases fetch once the checksum matches.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    imem_loader_if.master bus,
    output logic        loader_done,
    output logic        load_err,
    output logic [15:0] words_loaded,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        ST_HDR  = 3'd0,
        ST_DATA = 3'd1,
        ST_CSUM = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] shift_q, shift_d;
    logic [31:0] n_q, n_d;
    logic [31:0] csum_q, csum_d;
    logic [31:0] next_addr_q, next_addr_d;
    logic [15:0] words_q, words_d;
    logic        rx_ready_q, rx_ready_d;
    logic        we_q, we_d;
    logic [31:0] waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        xfer;
    logic        last_byte;
    logic [31:0] assembled;

    // Next-state and output computation; all outputs are registered from here.
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        shift_d     = shift_q;
        n_d         = n_q;
        csum_d      = csum_q;
        next_addr_d = next_addr_q;
        words_d     = words_q;
        we_d        = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;

        xfer      = bus.rx_valid & rx_ready_q;
        last_byte = (byte_cnt_q == 2'd3);
        // Bytes enter at the top and shift down, so byte0 lands in [7:0].
        assembled = {bus.rx_data, shift_q[31:8]};

        if (xfer) begin
            shift_d    = assembled;
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (last_byte) begin
                case (state_q)
                    ST_HDR: begin
                        n_d = assembled;
                        if (assembled > MAX_WORDS) begin
                            state_d = ST_ERR;
                        end else if (assembled == 32'd0) begin
                            state_d = ST_CSUM;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        we_d        = 1'b1;
                        waddr_d     = next_addr_q;
                        wdata_d     = assembled;
                        next_addr_d = next_addr_q + 32'd4;
                        words_d     = words_q + 16'd1;
                        csum_d      = csum_q ^ assembled;
                        if ({16'd0, words_d} == n_q) begin
                            state_d = ST_CSUM;
                        end
                    end
                    ST_CSUM: begin
                        state_d = (assembled == csum_q) ? ST_DONE : ST_ERR;
                    end
                    default: begin
                        state_d = state_q;
                    end
                endcase
            end
        end

        rx_ready_d = (state_d == ST_HDR) || (state_d == ST_DATA) || (state_d == ST_CSUM);
        done_d     = done_q | (state_d == ST_DONE);
        err_d      = err_q | (state_d == ST_ERR);
    end

    // Single state/output register bank; async reset returns to header capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_HDR;
            byte_cnt_q  <= 2'd0;
            shift_q     <= 32'd0;
            n_q         <= 32'd0;
            csum_q      <= 32'd0;
            next_addr_q <= BASE_ADDR;
            words_q     <= 16'd0;
            rx_ready_q  <= 1'b0;
            we_q        <= 1'b0;
            waddr_q     <= BASE_ADDR;
            wdata_q     <= 32'd0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            shift_q     <= shift_d;
            n_q         <= n_d;
            csum_q      <= csum_d;
            next_addr_q <= next_addr_d;
            words_q     <= words_d;
            rx_ready_q  <= rx_ready_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign bus.rx_ready   = rx_ready_q;
    assign bus.imem_we    = we_q;
    assign bus.imem_waddr = waddr_q;
    assign bus.imem_wdata = wdata_q;
    assign loader_done    = done_q;
    assign load_err       = err_q;
    assign words_loaded   = words_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: byte-stream driver, write scoreboard,
// end-of-stream status checks and a one-line report.
module tb_imem_loader;

    logic        clk;
    logic        rst;
    logic        loader_done;
    logic        load_err;
    logic [15:0] words_loaded;
    logic [2:0]  dbg_state;

    imem_loader_if bus ();

    imem_loader #(
        .BASE_ADDR(32'h0000_0000),
        .MAX_WORDS(256)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master),
        .loader_done(loader_done),
        .load_err(load_err),
        .words_loaded(words_loaded),
        .dbg_state(dbg_state)
    );

    int total;
    int bad;
    logic [63:0] exp_q[$];   // {addr, data} of each expected write
    logic [7:0]  stream [16];

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reset pulse with checks of every output while rst is held.
    task automatic do_reset();
        rst = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        @(negedge clk);
        @(negedge clk);
        check("rst_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
        check("rst_we", {31'd0, bus.imem_we}, 32'd0);
        check("rst_waddr", bus.imem_waddr, 32'h0);
        check("rst_wdata", bus.imem_wdata, 32'h0);
        check("rst_done", {31'd0, loader_done}, 32'd0);
        check("rst_err", {31'd0, load_err}, 32'd0);
        check("rst_words", {16'd0, words_loaded}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    // Driver: present one byte from a negedge and hold it until transferred.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int budget;
        if (gaps) begin
            bus.rx_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        budget = 0;
        while (!bus.rx_ready && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        if (!bus.rx_ready) begin
            total++;
            bad++;
            $display("FAIL rx_ready_timeout: got 0 expected 1 for byte 0x%02h", b);
        end else begin
            @(negedge clk);
        end
    endtask

    task automatic send_stream(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            send_byte(stream[i], gaps);
        end
        bus.rx_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic load_test1_stream(input logic [7:0] csum_b0);
        logic [7:0] s [16];
        s = '{8'h02, 8'h00, 8'h00, 8'h00,
              8'h13, 8'h00, 8'h00, 8'h00,
              8'h93, 8'h00, 8'h10, 8'h00,
              8'h80, 8'h00, 8'h10, 8'h00};
        s[12] = csum_b0;
        stream = s;
    endtask

    task automatic check_status(input string t, input logic done, input logic err,
                                input logic [15:0] words, input logic ready);
        check({t, "_done"}, {31'd0, loader_done}, {31'd0, done});
        check({t, "_err"}, {31'd0, load_err}, {31'd0, err});
        check({t, "_words"}, {16'd0, words_loaded}, {16'd0, words});
        check({t, "_rx_ready"}, {31'd0, bus.rx_ready}, {31'd0, ready});
        check({t, "_pending"}, exp_q.size(), 32'd0);
    endtask

    // Scoreboard monitor: every write strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus.imem_we) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL write_unexpected: got 0x%08h@0x%08h expected no write",
                         bus.imem_wdata, bus.imem_waddr);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({bus.imem_waddr, bus.imem_wdata} !== e) begin
                    bad++;
                    $display("FAIL write: got 0x%08h@0x%08h expected 0x%08h@0x%08h",
                             bus.imem_wdata, bus.imem_waddr, e[31:0], e[63:32]);
                end
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;

        // Test 1: two-word program, good checksum, back-to-back bytes
        do_reset();
        load_test1_stream(8'h80);
        exp_q.push_back({32'h0000_0000, 32'h0000_0013});
        exp_q.push_back({32'h0000_0004, 32'h0010_0093});
        send_stream(16, 1'b0);
        check_status("t1", 1'b1, 1'b0, 16'd2, 1'b0);
        check("t1_waddr_hold", bus.imem_waddr, 32'h0000_0004);
        check("t1_wdata_hold", bus.imem_wdata, 32'h0010_0093);
        check("t1_state", {29'd0, dbg_state}, 32'd3);

        // Test 2: same program, corrupted checksum byte0
        do_reset();
        load_test1_stream(8'h81);
        exp_q.push_back({32'h0000_0000, 32'h0000_0013});
        exp_q.push_back({32'h0000_0004, 32'h0010_0093});
        send_stream(16, 1'b0);
        check_status("t2", 1'b0, 1'b1, 16'd2, 1'b0);

        // Test 3: empty program, zero checksum
        do_reset();
        stream[0:7] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_stream(8, 1'b0);
        check_status("t3", 1'b1, 1'b0, 16'd0, 1'b0);

        // Test 4: length one above the limit, then bytes that must be ignored
        do_reset();
        stream[0:3] = '{8'h01, 8'h01, 8'h00, 8'h00};
        send_stream(4, 1'b0);
        check_status("t4", 1'b0, 1'b1, 16'd0, 1'b0);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'hAA;
        repeat (6) @(negedge clk);
        bus.rx_valid = 1'b0;
        check_status("t4_ignored", 1'b0, 1'b1, 16'd0, 1'b0);

        // Test 5: test 1 stream with random gaps in rx_valid
        do_reset();
        load_test1_stream(8'h80);
        exp_q.push_back({32'h0000_0000, 32'h0000_0013});
        exp_q.push_back({32'h0000_0004, 32'h0010_0093});
        send_stream(16, 1'b1);
        check_status("t5", 1'b1, 1'b0, 16'd2, 1'b0);

        // Test 6: abort after 6 bytes, then replay the full stream
        do_reset();
        load_test1_stream(8'h80);
        send_stream(6, 1'b0);
        check("t6_abort_words", {16'd0, words_loaded}, 32'd0);
        do_reset();
        exp_q.push_back({32'h0000_0000, 32'h0000_0013});
        exp_q.push_back({32'h0000_0004, 32'h0010_0093});
        send_stream(16, 1'b0);
        check_status("t6", 1'b1, 1'b0, 16'd2, 1'b0);
        check("t6_waddr_hold", bus.imem_waddr, 32'h0000_0004);
        check("t6_wdata_hold", bus.imem_wdata, 32'h0010_0093);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
